// File: rtl/shift_sub_div.sv
// Sequential restoring (shift-subtract) divider: N-bit unsigned quotient/remainder in N+2 cycles.
// Optional macro DIV_SERIAL_OUT_EN adds an MSB-first serial quotient stream (q_serial/q_valid).
module shift_sub_div #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  input  logic         DIV_EN,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         busy,
  output logic         done,
  output logic         div_zero
`ifdef DIV_SERIAL_OUT_EN
  ,
  output logic         q_serial,
  output logic         q_valid
`endif
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t         r_state, w_next;
  logic [N-1:0]   r_dvd, r_dsr, r_rem;
  logic [CW-1:0]  r_cnt;
  logic [N-1:0]   r_quotient, r_remainder;
  logic           r_done, r_div_zero;
  logic [N:0]     w_rem_sh;
  logic [N+1:0]   w_trial;
  logic           w_qbit;

  // Shifted partial remainder can reach N+1 bits; one extra bit holds the trial's sign.
  assign w_rem_sh = {r_rem, r_dvd[N-1]};
  assign w_trial  = {1'b0, w_rem_sh} - {2'b00, r_dsr};
  assign w_qbit   = ~w_trial[N+1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (DIV_EN) w_next = (divisor == '0) ? S_DONE : S_CALC;
      S_CALC: if (r_cnt == '0) w_next = S_DONE;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd       <= '0;
      r_dsr       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_done      <= 1'b0;
      r_div_zero  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (DIV_EN) begin
          r_dvd      <= dividend;
          r_dsr      <= divisor;
          r_rem      <= '0;
          r_cnt      <= CW'(N - 1);
          r_div_zero <= (divisor == '0);
        end
        S_CALC: begin
          r_rem <= w_qbit ? w_trial[N-1:0] : w_rem_sh[N-1:0];
          r_dvd <= {r_dvd[N-2:0], w_qbit};
          r_cnt <= r_cnt - 1'b1;
        end
        S_DONE: begin
          // Divide-by-zero never shifts, so r_dvd still holds the original dividend.
          r_quotient  <= r_div_zero ? '1 : r_dvd;
          r_remainder <= r_div_zero ? r_dvd : r_rem;
          r_done      <= 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifdef DIV_SERIAL_OUT_EN
  logic r_q_serial, r_q_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q_serial <= 1'b0;
      r_q_valid  <= 1'b0;
    end else begin
      r_q_valid  <= (r_state == S_CALC);
      r_q_serial <= (r_state == S_CALC) & w_qbit;
    end
  end

  assign q_serial = r_q_serial;
  assign q_valid  = r_q_valid;
`endif

  assign quotient  = r_quotient;
  assign remainder = r_remainder;
  assign busy      = (r_state != S_IDLE);
  assign done      = r_done;
  assign div_zero  = r_div_zero;

endmodule
